// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared types and constants for the register-bus request
//               sequencer: FSM state encoding, device-index field position
//               within the byte address, and the default error data word.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } bus_state_t;

    localparam int          DEVICE_MSB         = 31;
    localparam int          DEVICE_LSB         = 28;
    localparam logic [31:0] ERROR_DATA_DEFAULT = 32'hFFFF_FFFF;

endpackage : bus_pkg
`default_nettype wire

// File: rtl/bus_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : bus_timeout_counter
// Description : Saturating WAIT-cycle counter. Flags expiry when the count
//               reaches TIMEOUT_CYCLES-1 and then holds (never wraps).
// Ports       : i_clk     - clock
//               i_reset   - asynchronous active-high reset
//               i_clear   - synchronous clear to zero (has priority)
//               i_enable  - count one cycle
//               o_expired - count has reached TIMEOUT_CYCLES-1
// Revision    : 1.0 - initial release
// ============================================================================
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    assign o_expired = (r_count == C_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : bus_timeout_counter
`default_nettype wire

// File: rtl/bus_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bus_request_sequencer
// Description : Converts a master request stream into one-cycle read/write
//               strobes on a 32-bit register bus, waits for the addressed
//               slave's ack (with timeout) and returns one response per
//               accepted request.
// Ports       : i_clk/i_reset            - clock, async active-high reset
//               i_req_*/o_req_ready      - master request channel
//               o_rsp_valid/data/error   - 1-cycle response pulse
//               o_select/o_read_rq/o_write_rq/o_address/o_data - slave bus
//               i_ack/i_data             - per-slave ack and read data
// Revision    : 1.0 - initial release
// ============================================================================
module bus_request_sequencer
    import bus_pkg::*;
#(
    parameter int          NUM_DEVICES    = 4,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERROR_DATA     = ERROR_DATA_DEFAULT
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic                      i_req_write,
    input  logic [31:0]               i_req_address,
    input  logic [31:0]               i_req_data,
    output logic                      o_rsp_valid,
    output logic [31:0]               o_rsp_data,
    output logic                      o_rsp_error,
    output logic [NUM_DEVICES-1:0]    o_select,
    output logic                      o_read_rq,
    output logic                      o_write_rq,
    output logic [31:0]               o_address,
    output logic [31:0]               o_data,
    input  logic [NUM_DEVICES-1:0]    i_ack,
    input  logic [32*NUM_DEVICES-1:0] i_data
);

    localparam int IDX_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;

    bus_state_t        r_state;
    bus_state_t        w_next_state;
    logic              r_started;   // keeps ready low until the first edge after reset
    logic              r_write;
    logic [IDX_W-1:0]  r_sel;
    logic              r_error;
    logic [31:0]       r_rsp_data;
    logic [31:0]       r_address;
    logic [31:0]       r_data;

    logic [DEVICE_MSB-DEVICE_LSB:0] w_idx;
    logic                           w_idx_valid;
    logic                           w_accept;
    logic                           w_ack;
    logic [31:0]                    w_slot;
    logic                           w_expired;
    logic                           w_selecting;

    assign w_idx       = i_req_address[DEVICE_MSB:DEVICE_LSB];
    assign w_idx_valid = (32'(w_idx) < NUM_DEVICES);
    assign o_req_ready = (r_state == S_IDLE) && r_started;
    assign w_accept    = o_req_ready && i_req_valid;
    assign w_selecting = (r_state == S_ISSUE) || (r_state == S_WAIT);

    // Ack select and read-data mux on the captured device index; acks from
    // any other slave never reach the FSM.
    always_comb begin
        w_ack  = 1'b0;
        w_slot = '0;
        for (int k = 0; k < NUM_DEVICES; k++) begin
            if (r_sel == IDX_W'(k)) begin
                w_ack  = i_ack[k];
                w_slot = i_data[k*32 +: 32];
            end
        end
    end

    always_comb begin
        o_select = '0;
        for (int k = 0; k < NUM_DEVICES; k++) begin
            o_select[k] = w_selecting && (r_sel == IDX_W'(k));
        end
    end

    assign o_read_rq   = (r_state == S_ISSUE) && !r_write;
    assign o_write_rq  = (r_state == S_ISSUE) &&  r_write;
    assign o_rsp_valid = (r_state == S_RESPOND);
    assign o_rsp_data  = o_rsp_valid ? r_rsp_data : '0;
    assign o_rsp_error = o_rsp_valid && r_error;
    assign o_address   = r_address;
    assign o_data      = r_data;

    bus_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (r_state == S_ISSUE),
        .i_enable  (r_state == S_WAIT),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_started <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_started <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_idx_valid ? S_ISSUE : S_RESPOND;
                end
            end
            S_ISSUE:   w_next_state = S_WAIT;
            S_WAIT: begin
                // Ack checked first so an ack coinciding with expiry wins.
                if (w_ack || w_expired) begin
                    w_next_state = S_RESPOND;
                end
            end
            S_RESPOND: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_write    <= 1'b0;
            r_sel      <= '0;
            r_address  <= '0;
            r_data     <= '0;
            r_error    <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_write   <= i_req_write;
                r_sel     <= IDX_W'(w_idx);
                r_address <= i_req_address;
                r_data    <= i_req_data;
                r_error   <= !w_idx_valid;
                r_rsp_data <= w_idx_valid ? 32'd0 : ERROR_DATA;
            end
            if (r_state == S_WAIT) begin
                if (w_ack) begin
                    r_error    <= 1'b0;
                    r_rsp_data <= r_write ? 32'd0 : w_slot;
                end else if (w_expired) begin
                    r_error    <= 1'b1;
                    r_rsp_data <= ERROR_DATA;
                end
            end
        end
    end

endmodule : bus_request_sequencer
`default_nettype wire

// File: tb/tb_bus_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_request_sequencer
// Description : Directed self-checking bench for bus_request_sequencer
//               (NUM_DEVICES=4, TIMEOUT_CYCLES=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_request_sequencer;

    localparam int NDEV = 4;
    localparam int TMO  = 8;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [31:0]       req_address;
    logic [31:0]       req_data;
    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic              rsp_error;
    logic [NDEV-1:0]   sel;
    logic              read_rq;
    logic              write_rq;
    logic [31:0]       address;
    logic [31:0]       data;
    logic [NDEV-1:0]   ack;
    logic [32*NDEV-1:0] sdata;

    int checks = 0;
    int errors = 0;

    bus_request_sequencer #(
        .NUM_DEVICES    (NDEV),
        .TIMEOUT_CYCLES (TMO),
        .ERROR_DATA     (32'hFFFF_FFFF)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_write   (req_write),
        .i_req_address (req_address),
        .i_req_data    (req_data),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_data    (rsp_data),
        .o_rsp_error   (rsp_error),
        .o_select      (sel),
        .o_read_rq     (read_rq),
        .o_write_rq    (write_rq),
        .o_address     (address),
        .o_data        (data),
        .i_ack         (ack),
        .i_data        (sdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_valid   = 1'b1;
        req_write   = wr;
        req_address = a;
        req_data    = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 0; req_write = 0; req_address = 0; req_data = 0;
        ack = '0; sdata = '0;
        #2;
        checks++;
        if ({req_ready, rsp_valid, rsp_error, sel, read_rq, write_rq} !== 9'd0 ||
            rsp_data !== 32'd0 || address !== 32'd0 || data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b rspv=%b sel=%b addr=%h data=%h, expected all 0",
                     req_ready, rsp_valid, sel, address, data);
        end
        step();
        #2 rst = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_first_clk: got %b expected 0", req_ready);
        end
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_first_clk: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_read();
        drive_req(1'b0, 32'h0000_0004, 32'h0);           // T0
        step(); req_valid = 0;                            // T1
        checks++;
        if (read_rq !== 1'b1 || write_rq !== 1'b0 || sel !== 4'b0001 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL read_issue: rd=%b wr=%b sel=%b rdy=%b expected 1 0 0001 0",
                     read_rq, write_rq, sel, req_ready);
        end
        step();                                           // T2
        checks++;
        if (read_rq !== 1'b0 || sel !== 4'b0001 || rsp_valid !== 1'b0 || address !== 32'h4) begin
            errors++;
            $display("FAIL read_wait: rd=%b sel=%b rspv=%b addr=%h expected 0 0001 0 00000004",
                     read_rq, sel, rsp_valid, address);
        end
        ack = 4'b0001; sdata[0 +: 32] = 32'h0000_00AB;
        step(); ack = '0;                                 // T3
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hAB || rsp_error !== 1'b0 || sel !== 4'b0) begin
            errors++;
            $display("FAIL read_rsp: v=%b data=%h err=%b sel=%b expected 1 000000ab 0 0000",
                     rsp_valid, rsp_data, rsp_error, sel);
        end
        step();                                           // T4
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_return_idle: rspv=%b rdy=%b expected 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_write();
        sdata[32 +: 32] = 32'hDEAD_BEEF;                  // must not appear on a write response
        drive_req(1'b1, 32'h1000_0000, 32'h0000_001F);
        step(); req_valid = 0;
        checks++;
        if (write_rq !== 1'b1 || read_rq !== 1'b0 || sel !== 4'b0010 || data !== 32'h1F ||
            address !== 32'h1000_0000) begin
            errors++;
            $display("FAIL write_issue: wr=%b rd=%b sel=%b data=%h addr=%h expected 1 0 0010 0000001f 10000000",
                     write_rq, read_rq, sel, data, address);
        end
        step();
        ack = 4'b0010;
        step(); ack = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_data !== 32'd0) begin
            errors++;
            $display("FAIL write_rsp: v=%b err=%b data=%h expected 1 0 00000000",
                     rsp_valid, rsp_error, rsp_data);
        end
        step();
    endtask

    task automatic test_bad_device();
        drive_req(1'b0, 32'h7000_0000, 32'h0);
        step(); req_valid = 0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_data !== 32'hFFFF_FFFF ||
            sel !== 4'b0 || read_rq !== 1'b0 || write_rq !== 1'b0) begin
            errors++;
            $display("FAIL bad_device_rsp: v=%b err=%b data=%h sel=%b rd=%b wr=%b expected 1 1 ffffffff 0000 0 0",
                     rsp_valid, rsp_error, rsp_data, sel, read_rq, write_rq);
        end
        step();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bad_device_idle: rdy=%b rspv=%b expected 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        drive_req(1'b0, 32'h2000_0010, 32'h0);
        step(); req_valid = 0;                            // ISSUE
        for (int i = 0; i < TMO; i++) begin
            step();                                       // WAIT cycles 1..8
            if (rsp_valid !== 1'b0 || sel !== 4'b0100) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL timeout_wait: %0d WAIT cycles had rsp or wrong select, expected 0", early);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_data !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL timeout_rsp: v=%b err=%b data=%h expected 1 1 ffffffff",
                     rsp_valid, rsp_error, rsp_data);
        end
        step();
    endtask

    task automatic test_ignore_other_ack();
        int spurious;
        spurious = 0;
        sdata[0 +: 32]  = 32'h0000_0055;
        sdata[64 +: 32] = 32'h0000_0222;
        drive_req(1'b0, 32'h0000_0010, 32'h0);
        step(); req_valid = 0;                            // T1 ISSUE
        step();                                           // T2 WAIT
        ack = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step();                                       // T3..T5
            if (rsp_valid !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            errors++;
            $display("FAIL other_ack_ignored: %0d cycles with rsp, expected 0", spurious);
        end
        ack = 4'b0001;
        step(); ack = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h55 || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL other_ack_rsp: v=%b data=%h err=%b expected 1 00000055 0",
                     rsp_valid, rsp_data, rsp_error);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        drive_req(1'b1, 32'h3000_0008, 32'h0000_0099);
        step(); req_valid = 0;
        step();                                           // WAIT
        #2 rst = 1'b1;
        #1;
        checks++;
        if (sel !== 4'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0 ||
            address !== 32'd0 || data !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_async: sel=%b rdy=%b rspv=%b addr=%h data=%h expected all 0",
                     sel, req_ready, rsp_valid, address, data);
        end
        step();
        #2 rst = 1'b0;
        ack = 4'b1000;                                    // late ack from aborted transfer
        for (int i = 0; i < 2; i++) begin
            step();
            if (rsp_valid !== 1'b0) seen++;
        end
        ack = '0;
        checks++;
        if (seen != 0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_no_rsp: rsp cycles=%0d rdy=%b expected 0 1", seen, req_ready);
        end
        sdata[96 +: 32] = 32'h0000_3333;
        drive_req(1'b0, 32'h3000_000C, 32'h0);
        step(); req_valid = 0;
        checks++;
        if (read_rq !== 1'b1 || sel !== 4'b1000) begin
            errors++;
            $display("FAIL reset_mid_reissue: rd=%b sel=%b expected 1 1000", read_rq, sel);
        end
        step();
        ack = 4'b1000;
        step(); ack = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h3333 || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_recover: v=%b data=%h err=%b expected 1 00003333 0",
                     rsp_valid, rsp_data, rsp_error);
        end
    endtask

    task automatic test_back_to_back();
        // Called right after a RESPOND cycle: next accept lands on T4.
        step();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: got %b expected 1", req_ready);
        end
        drive_req(1'b1, 32'h2000_0020, 32'h0000_00C3);
        step();
        // Inputs change while busy; captured values must hold.
        drive_req(1'b0, 32'h1000_0FFF, 32'h1234_5678);
        checks++;
        if (write_rq !== 1'b1 || sel !== 4'b0100 || address !== 32'h2000_0020 || data !== 32'hC3) begin
            errors++;
            $display("FAIL b2b_issue: wr=%b sel=%b addr=%h data=%h expected 1 0100 20000020 000000c3",
                     write_rq, sel, address, data);
        end
        step();
        checks++;
        if (address !== 32'h2000_0020 || data !== 32'hC3 || read_rq !== 1'b0 || write_rq !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold: addr=%h data=%h rd=%b wr=%b expected 20000020 000000c3 0 0",
                     address, data, read_rq, write_rq);
        end
        req_valid = 0;
        ack = 4'b0100;
        step(); ack = '0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_data !== 32'd0) begin
            errors++;
            $display("FAIL b2b_rsp: v=%b err=%b data=%h expected 1 0 00000000",
                     rsp_valid, rsp_error, rsp_data);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_bad_device();
        test_timeout();
        test_ignore_other_ack();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_bus_request_sequencer
`default_nettype wire
